rob_drain_ctrl: RTL and testbench

//  In-order retire stage of the reorder buffer, downstream of the valid bitmap and entry data RAM.
//  - Walks a head pointer over the 2**ADDR_WIDTH slots and waits until the head slot's valid bit is set.
//  - Reads the slot payload from the data RAM and presents it on a valid/ready output port.
//  - Pulses a bitmap clear after the last slot of a pass retires, so the next pass starts from an empty bitmap.

---
 rtl/rob_drain_ctrl_if.sv | 25 ++
 rtl/rob_drain_ctrl.sv | 113 +++++++++++
 tb/tb_rob_drain_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_drain_ctrl_if.sv
// Retire-port bundle of the reorder-buffer drain stage.
// The master drives valid/data/id; the slave answers with ready.
interface rob_drain_ctrl_if #(
    parameter int AW = 4,
    parameter int DW = 32
);
    logic          m_valid_o;
    logic          m_ready_i;
    logic [DW-1:0] m_data_o;
    logic [AW-1:0] m_id_o;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_id_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_id_o,
        output m_ready_i
    );
endinterface

// File: rtl/rob_drain_ctrl.sv
// In-order ROB retire stage: head-pointer walk, RAM fetch, valid/ready out.
// Optional ROB_DRAIN_FLUSH_EN adds flush_i (pass abort + bitmap clear).
module rob_drain_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] vm_addr_read_o,
    input  logic                  vm_valid_i,
    output logic                  vm_clear_o,
    output logic                  dm_rd_en_o,
    output logic [ADDR_WIDTH-1:0] dm_addr_o,
    input  logic [DATA_WIDTH-1:0] dm_data_i,
`ifdef ROB_DRAIN_FLUSH_EN
    input  logic                  flush_i,
`endif
    rob_drain_ctrl_if.master      m
);
    typedef enum logic [1:0] {
        S_WAIT,
        S_FETCH,
        S_HOLD
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;
    logic                    valid;
    logic                    valid_nxt;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic [ADDR_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0]   id_nxt;
    logic                    handshake;
    logic                    wrap;
    logic                    flush;

`ifdef ROB_DRAIN_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign vm_addr_read_o = ptr;
    assign dm_addr_o      = ptr;
    assign m.m_valid_o    = valid;
    assign m.m_data_o     = data;
    assign m.m_id_o       = id;
    assign handshake      = valid & m.m_ready_i;
    assign vm_clear_o     = wrap | flush;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        valid_nxt  = valid;
        data_nxt   = data;
        id_nxt     = id;
        dm_rd_en_o = 1'b0;
        wrap       = 1'b0;
        unique case (state)
            S_WAIT: begin
                dm_rd_en_o = vm_valid_i;
                if (vm_valid_i) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                data_nxt  = dm_data_i;
                id_nxt    = ptr;
                valid_nxt = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (handshake) begin
                    ptr_nxt   = ptr + 1'b1;
                    valid_nxt = 1'b0;
                    state_nxt = S_WAIT;
                    // Last slot of the pass: bitmap clears as ptr wraps to 0
                    wrap      = (ptr == LAST);
                end
            end
            default: begin
                state_nxt = S_WAIT;
            end
        endcase
        // Abort wins over any handshake in the same cycle
        if (flush) begin
            state_nxt = S_WAIT;
            ptr_nxt   = '0;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
            ptr   <= '0;
            valid <= 1'b0;
            data  <= '0;
            id    <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            valid <= valid_nxt;
            data  <= data_nxt;
            id    <= id_nxt;
        end
    end
endmodule

// File: tb/tb_rob_drain_ctrl.sv
// Directed bench for rob_drain_ctrl with bitmap/RAM models.
// A second instance with ADDR_WIDTH=2 exercises the pass wrap.
module tb_rob_drain_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Instance 1: AW=4
    rob_drain_ctrl_if #(.AW(4), .DW(32)) m1();
    logic [3:0]  vm_addr1;
    logic        vm_valid1;
    logic        vm_clear1;
    logic        rd_en1;
    logic [3:0]  dm_addr1;
    logic [31:0] dq1;
    logic [15:0] bm1 = '0;
    logic [15:0] set1 = '0;
    logic [31:0] dmem1 [16];
    logic        flush = 1'b0;

    // Instance 2: AW=2
    rob_drain_ctrl_if #(.AW(2), .DW(32)) m2();
    logic [1:0]  vm_addr2;
    logic        vm_valid2;
    logic        vm_clear2;
    logic        rd_en2;
    logic [1:0]  dm_addr2;
    logic [31:0] dq2;
    logic [3:0]  bm2 = '0;
    logic [3:0]  set2 = '0;
    logic [31:0] dmem2 [4];

    rob_drain_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .vm_addr_read_o (vm_addr1),
        .vm_valid_i     (vm_valid1),
        .vm_clear_o     (vm_clear1),
        .dm_rd_en_o     (rd_en1),
        .dm_addr_o      (dm_addr1),
        .dm_data_i      (dq1),
`ifdef ROB_DRAIN_FLUSH_EN
        .flush_i        (flush),
`endif
        .m              (m1)
    );

    rob_drain_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32)) u_dut2 (
        .clk            (clk),
        .rst            (rst),
        .vm_addr_read_o (vm_addr2),
        .vm_valid_i     (vm_valid2),
        .vm_clear_o     (vm_clear2),
        .dm_rd_en_o     (rd_en2),
        .dm_addr_o      (dm_addr2),
        .dm_data_i      (dq2),
`ifdef ROB_DRAIN_FLUSH_EN
        .flush_i        (1'b0),
`endif
        .m              (m2)
    );

    // Bitmap and RAM models: clear beats set, RAM has 1-cycle latency
    assign vm_valid1 = bm1[vm_addr1];
    assign vm_valid2 = bm2[vm_addr2];

    always @(posedge clk) begin
        if (rst || vm_clear1) bm1 <= '0;
        else bm1 <= bm1 | set1;
        if (rd_en1) dq1 <= dmem1[dm_addr1];
        if (rst || vm_clear2) bm2 <= '0;
        else bm2 <= bm2 | set2;
        if (rd_en2) dq2 <= dmem2[dm_addr2];
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [31:0] exp3 [3];
    int k;
    int hs;
    int nclr;
    logic after;

    initial begin
        m1.m_ready_i = 1'b0;
        m2.m_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) dmem1[i] = '0;
        for (int i = 0; i < 4; i++) dmem2[i] = 32'h30 + 32'(i);
        exp3[0] = 32'h00;
        exp3[1] = 32'h11;
        exp3[2] = 32'h22;

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(m1.m_valid_o), 0);
        chk("rst_data", m1.m_data_o, 0);
        chk("rst_id", 32'(m1.m_id_o), 0);
        chk("rst_clear", 32'(vm_clear1), 0);
        chk("rst_rden", 32'(rd_en1), 0);
        chk("rst_addr", 32'(vm_addr1), 0);

        // 1: slot 0 = 0xA5, latency N -> N+2
        dmem1[0] = 32'hA5;
        set1 = 16'h0001;
        cyc();
        set1 = '0;
        #1;
        chk("t1_rden", 32'(rd_en1), 1);
        chk("t1_dmaddr", 32'(dm_addr1), 0);
        cyc();
        chk("t1_valid_n1", 32'(m1.m_valid_o), 0);
        cyc();
        chk("t1_valid", 32'(m1.m_valid_o), 1);
        chk("t1_data", m1.m_data_o, 32'hA5);
        chk("t1_id", 32'(m1.m_id_o), 0);

        // 2: stall 5 cycles, accept on the 6th
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_valid", 32'(m1.m_valid_o), 1);
            chk("t2_data", m1.m_data_o, 32'hA5);
            chk("t2_id", 32'(m1.m_id_o), 0);
            chk("t2_ptr", 32'(vm_addr1), 0);
        end
        m1.m_ready_i = 1'b1;
        cyc();
        m1.m_ready_i = 1'b0;
        chk("t2_done_valid", 32'(m1.m_valid_o), 0);
        chk("t2_done_ptr", 32'(vm_addr1), 1);

        // 3: out-of-order set, in-order retire
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        dmem1[0] = 32'h00;
        dmem1[1] = 32'h11;
        dmem1[2] = 32'h22;
        m1.m_ready_i = 1'b1;
        set1 = 16'h0004;
        cyc();
        set1 = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_idle_a", 32'(m1.m_valid_o), 0);
        end
        set1 = 16'h0002;
        cyc();
        set1 = '0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_idle_b", 32'(m1.m_valid_o), 0);
        end
        set1 = 16'h0001;
        cyc();
        set1 = '0;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (m1.m_valid_o && k < 3) begin
                chk("t3_id", 32'(m1.m_id_o), 32'(k));
                chk("t3_data", m1.m_data_o, exp3[k]);
                k++;
            end else if (m1.m_valid_o) begin
                chk("t3_extra", 32'(m1.m_valid_o), 0);
            end
        end
        chk("t3_count", 32'(k), 3);

        // 5: reset while holding id 5
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) dmem1[i] = 32'h50 + 32'(i);
        m1.m_ready_i = 1'b1;
        set1 = 16'h001F;
        cyc();
        set1 = '0;
        for (int i = 0; i < 40 && vm_addr1 != 4'd5; i++) cyc();
        chk("t5_reach5", 32'(vm_addr1), 5);
        m1.m_ready_i = 1'b0;
        set1 = 16'h0020;
        cyc();
        set1 = '0;
        for (int i = 0; i < 10 && !m1.m_valid_o; i++) cyc();
        chk("t5_hold_valid", 32'(m1.m_valid_o), 1);
        chk("t5_hold_id", 32'(m1.m_id_o), 5);
        chk("t5_hold_data", m1.m_data_o, 32'h55);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5_valid", 32'(m1.m_valid_o), 0);
        chk("t5_ptr", 32'(vm_addr1), 0);
        chk("t5_clear", 32'(vm_clear1), 0);
        dmem1[0] = 32'h5A;
        m1.m_ready_i = 1'b1;
        set1 = 16'h0001;
        cyc();
        set1 = '0;
        for (int i = 0; i < 10 && !m1.m_valid_o; i++) cyc();
        chk("t5_re_valid", 32'(m1.m_valid_o), 1);
        chk("t5_re_id", 32'(m1.m_id_o), 0);
        chk("t5_re_data", m1.m_data_o, 32'h5A);
        cyc();
        chk("t5_re_ptr", 32'(vm_addr1), 1);

`ifdef ROB_DRAIN_FLUSH_EN
        // 6: flush while holding id 3
        set1 = 16'h0006;
        cyc();
        set1 = '0;
        for (int i = 0; i < 20 && vm_addr1 != 4'd3; i++) cyc();
        chk("t6_reach3", 32'(vm_addr1), 3);
        m1.m_ready_i = 1'b0;
        dmem1[3] = 32'h33;
        set1 = 16'h0008;
        cyc();
        set1 = '0;
        for (int i = 0; i < 10 && !m1.m_valid_o; i++) cyc();
        chk("t6_hold_id", 32'(m1.m_id_o), 3);
        flush = 1'b1;
        #1;
        chk("t6_clear", 32'(vm_clear1), 1);
        cyc();
        flush = 1'b0;
        #1;
        chk("t6_valid", 32'(m1.m_valid_o), 0);
        chk("t6_ptr", 32'(vm_addr1), 0);
        chk("t6_rden", 32'(rd_en1), 0);
        chk("t6_clear_off", 32'(vm_clear1), 0);
`endif

        // 4: AW=2 full pass and wrap
        m2.m_ready_i = 1'b1;
        set2 = 4'hF;
        cyc();
        set2 = '0;
        hs = 0;
        nclr = 0;
        after = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            #1;
            if (after) begin
                chk("t4_wrap_ptr", 32'(vm_addr2), 0);
                chk("t4_wrap_bm", 32'(vm_valid2), 0);
                after = 1'b0;
            end
            if (vm_clear2) nclr++;
            if (m2.m_valid_o) begin
                chk("t4_id", 32'(m2.m_id_o), 32'(hs));
                chk("t4_data", m2.m_data_o, 32'h30 + 32'(hs));
                chk("t4_clear", 32'(vm_clear2), 32'(hs == 3));
                if (hs == 3) after = 1'b1;
                hs++;
            end
        end
        chk("t4_handshakes", 32'(hs), 4);
        chk("t4_clear_pulses", 32'(nclr), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end
endmodule
